// File: rtl/multi_port_fifo.sv
// rtl/multi_port_fifo.sv - multi-lane synchronous FIFO with all-or-nothing push/pop, flush and sticky error
module multi_port_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int WR_PORTS     = 2,
  parameter int RD_PORTS     = 2,
  parameter int AFULL_THRESH = 12,
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int CW  = AW + 1,
  localparam int WNW = $clog2(WR_PORTS + 1),
  localparam int RNW = $clog2(RD_PORTS + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_flush,
  input  logic [WNW-1:0]                 i_wr_num,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] i_wr_data,
  output logic                           o_wr_ok,
  input  logic [RNW-1:0]                 i_rd_num,
  output logic                           o_rd_ok,
  output logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
  output logic [RD_PORTS-1:0]            o_rd_valid,
  output logic [CW-1:0]                  o_count,
  output logic [CW-1:0]                  o_free,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_almost_full,
  output logic                           o_err
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_err;

  logic [CW-1:0]         w_free;
  logic                  w_wr_fit;
  logic                  w_rd_fit;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [AW-1:0]         w_waddr [WR_PORTS];
  logic [AW-1:0]         w_raddr [RD_PORTS];

  assign w_free = CW'(FIFO_DEPTH) - r_count;

  // A request wider than the lane count is rejected even if space would allow it.
  assign w_wr_fit = (int'(i_wr_num) <= WR_PORTS) && (int'(i_wr_num) <= int'(w_free));
  assign w_rd_fit = (int'(i_rd_num) <= RD_PORTS) && (int'(i_rd_num) <= int'(r_count));
  assign w_wr_ok  = w_wr_fit && !i_flush;
  assign w_rd_ok  = w_rd_fit && !i_flush;

  always_comb begin
    for (int k = 0; k < WR_PORTS; k++) begin
      w_waddr[k] = r_wptr + AW'(k);
    end
    for (int k = 0; k < RD_PORTS; k++) begin
      w_raddr[k] = r_rptr + AW'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + AW'(i_wr_num);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + AW'(i_rd_num);
      end
      r_count <= r_count + (w_wr_ok ? CW'(i_wr_num) : '0) - (w_rd_ok ? CW'(i_rd_num) : '0);
      if (!w_wr_fit || !w_rd_fit) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; only lanes below i_wr_num are written.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (k < int'(i_wr_num)) begin
          r_mem[w_waddr[k]] <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    o_rd_data  = '0;
    o_rd_valid = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_raddr[k]];
      o_rd_valid[k]                         = int'(r_count) > k;
    end
  end

  assign o_wr_ok       = w_wr_ok;
  assign o_rd_ok       = w_rd_ok;
  assign o_count       = r_count;
  assign o_free        = w_free;
  assign o_full        = (r_count == CW'(FIFO_DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_almost_full = (r_count >= CW'(AFULL_THRESH));
  assign o_err         = r_err;

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge i_clk) disable iff (!i_rstn)
    int'(r_count) <= FIFO_DEPTH);
  a_ptr_count : assert property (@(posedge i_clk) disable iff (!i_rstn)
    (r_wptr - r_rptr) == r_count[AW-1:0]);
`endif

endmodule

// File: tb/tb_multi_port_fifo.sv
// tb/tb_multi_port_fifo.sv - directed self-checking bench for multi_port_fifo
module tb_multi_port_fifo;

  logic        i_clk;
  logic        i_rstn;
  logic        i_flush;
  logic [1:0]  i_wr_num;
  logic [63:0] i_wr_data;
  logic        o_wr_ok;
  logic [1:0]  i_rd_num;
  logic        o_rd_ok;
  logic [63:0] o_rd_data;
  logic [1:0]  o_rd_valid;
  logic [4:0]  o_count;
  logic [4:0]  o_free;
  logic        o_full;
  logic        o_empty;
  logic        o_almost_full;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;

  multi_port_fifo dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_flush       (i_flush),
    .i_wr_num      (i_wr_num),
    .i_wr_data     (i_wr_data),
    .o_wr_ok       (o_wr_ok),
    .i_rd_num      (i_rd_num),
    .o_rd_ok       (o_rd_ok),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_count       (o_count),
    .o_free        (o_free),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_almost_full (o_almost_full),
    .o_err         (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wn, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rn, input logic fl);
    i_wr_num  = wn;
    i_wr_data = {d1, d0};
    i_rd_num  = rn;
    i_flush   = fl;
    #1;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    i_wr_num = '0;
    i_rd_num = '0;
    i_flush  = 1'b0;
    #1;
  endtask

  initial begin
    int cnt;
    i_rstn    = 1'b0;
    i_flush   = 1'b0;
    i_wr_num  = '0;
    i_rd_num  = '0;
    i_wr_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_full", 64'(o_full), 64'd0);
    check("rst_afull", 64'(o_almost_full), 64'd0);
    check("rst_free", 64'(o_free), 64'd16);
    check("rst_valid", 64'(o_rd_valid), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    i_rstn = 1'b1;
    step();

    drive(2'd2, 32'hA, 32'hB, 2'd0, 1'b0);
    check("push2_ok", 64'(o_wr_ok), 64'd1);
    check("no_bypass_valid", 64'(o_rd_valid), 64'd0);
    step();
    check("push2_count", 64'(o_count), 64'd2);
    check("push2_lane0", 64'(o_rd_data[31:0]), 64'hA);
    check("push2_lane1", 64'(o_rd_data[63:32]), 64'hB);
    check("push2_valid", 64'(o_rd_valid), 64'b11);
    check("push2_empty", 64'(o_empty), 64'd0);

    // Entry at index j holds 0x100+j from here on (j >= 2).
    for (int i = 0; i < 7; i++) begin
      cnt = 2 + 2 * i;
      drive(2'd2, 32'h100 + 32'(cnt), 32'h101 + 32'(cnt), 2'd0, 1'b0);
      check("fill_ok", 64'(o_wr_ok), 64'd1);
      step();
      check("fill_count", 64'(o_count), 64'(cnt + 2));
      check("fill_afull", 64'(o_almost_full), 64'(cnt + 2 >= 12));
      check("fill_full", 64'(o_full), 64'(cnt + 2 == 16));
    end
    check("full_free", 64'(o_free), 64'd0);
    check("full_err_pre", 64'(o_err), 64'd0);
    drive(2'd1, 32'hDEAD, 32'h0, 2'd0, 1'b0);
    check("over_push_ok", 64'(o_wr_ok), 64'd0);
    step();
    check("over_push_count", 64'(o_count), 64'd16);
    check("over_push_err", 64'(o_err), 64'd1);

    drive(2'd2, 32'hEE, 32'hFF, 2'd2, 1'b0);
    check("full_pp_wr_ok", 64'(o_wr_ok), 64'd0);
    check("full_pp_rd_ok", 64'(o_rd_ok), 64'd1);
    step();
    check("full_pp_count", 64'(o_count), 64'd14);
    check("full_pp_err", 64'(o_err), 64'd1);

    for (int j = 2; j < 16; j += 2) begin
      check("drain_lane0", 64'(o_rd_data[31:0]), 64'h100 + 64'(j));
      check("drain_lane1", 64'(o_rd_data[63:32]), 64'h101 + 64'(j));
      drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0);
      step();
    end
    check("drain_empty", 64'(o_empty), 64'd1);

    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    check("flush_err_clr", 64'(o_err), 64'd0);
    drive(2'd1, 32'h55, 32'h0, 2'd0, 1'b0);
    step();
    drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0);
    check("under_pop_ok", 64'(o_rd_ok), 64'd0);
    step();
    check("under_pop_count", 64'(o_count), 64'd1);
    check("under_pop_err", 64'(o_err), 64'd1);
    check("under_pop_head", 64'(o_rd_data[31:0]), 64'h55);
    drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0);
    check("pop1_ok", 64'(o_rd_ok), 64'd1);
    step();
    check("pop1_count", 64'(o_count), 64'd0);
    check("pop1_empty", 64'(o_empty), 64'd1);

    drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      drive((i == 7) ? 2'd1 : 2'd2, 32'h0, 32'h0, 2'd0, 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(2'd0, 32'h0, 32'h0, (i == 7) ? 2'd1 : 2'd2, 1'b0);
      step();
    end
    check("wrap_wptr", 64'(dut.r_wptr), 64'd15);
    check("wrap_rptr", 64'(dut.r_rptr), 64'd15);
    drive(2'd2, 32'h1, 32'h2, 2'd0, 1'b0);
    check("wrap_push_ok", 64'(o_wr_ok), 64'd1);
    step();
    check("wrap_count", 64'(o_count), 64'd2);
    check("wrap_lane0", 64'(o_rd_data[31:0]), 64'h1);
    check("wrap_lane1", 64'(o_rd_data[63:32]), 64'h2);
    drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    check("wrap_empty", 64'(o_empty), 64'd1);
    check("wrap_wptr_end", 64'(dut.r_wptr), 64'd1);
    check("wrap_rptr_end", 64'(dut.r_rptr), 64'd1);

    drive(2'd2, 32'h11, 32'h12, 2'd0, 1'b0);
    step();
    drive(2'd2, 32'h13, 32'h14, 2'd0, 1'b0);
    step();
    drive(2'd1, 32'h15, 32'h0, 2'd0, 1'b0);
    step();
    drive(2'd0, 32'h0, 32'h0, 2'd3, 1'b0);
    check("illegal_rd_ok", 64'(o_rd_ok), 64'd0);
    step();
    check("illegal_rd_count", 64'(o_count), 64'd5);
    check("illegal_rd_err", 64'(o_err), 64'd1);
    drive(2'd2, 32'h77, 32'h78, 2'd0, 1'b1);
    check("flush_wr_ok", 64'(o_wr_ok), 64'd0);
    check("flush_rd_ok", 64'(o_rd_ok), 64'd0);
    step();
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_empty", 64'(o_empty), 64'd1);
    check("flush_err", 64'(o_err), 64'd0);
    check("flush_wptr", 64'(dut.r_wptr), 64'd0);

    drive(2'd3, 32'h0, 32'h0, 2'd0, 1'b0);
    check("illegal_wr_ok", 64'(o_wr_ok), 64'd0);
    step();
    check("illegal_wr_count", 64'(o_count), 64'd0);
    check("illegal_wr_err", 64'(o_err), 64'd1);
    drive(2'd2, 32'h21, 32'h22, 2'd0, 1'b0);
    step();
    check("pre_rst_count", 64'(o_count), 64'd2);
    drive(2'd2, 32'h23, 32'h24, 2'd0, 1'b0);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async_rst_count", 64'(o_count), 64'd0);
    check("async_rst_empty", 64'(o_empty), 64'd1);
    check("async_rst_free", 64'(o_free), 64'd16);
    check("async_rst_valid", 64'(o_rd_valid), 64'd0);
    check("async_rst_err", 64'(o_err), 64'd0);
    check("async_rst_full", 64'(o_full), 64'd0);
    step();
    i_rstn = 1'b1;
    step();
    check("post_rst_count", 64'(o_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
